f_ifq: RTL and testbench

- Instruction fetch queue: the consumer end of the fetch interface.
- Accepts {pc, instr} pairs from the fetch unit and generates that unit's PC write-enable as backpressure.
- Buffers up to DEPTH fetched instructions and presents them in order to the decode stage.
- Sits between F and D in the pipeline; a redirect (branch/jump resolution) flushes all buffered entries.

---
 rtl/f_ifq_pkg.sv | 17 +
 rtl/f_ifq_mem.sv | 29 ++
 rtl/f_ifq.sv | 115 +++++++++++
 tb/tb_f_ifq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/f_ifq_pkg.sv
// Shared constants and payload type for the instruction fetch queue.
package f_ifq_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned IFQ_DEPTH = 4;

    // Decode sees this PC/instruction pair whenever the queue has nothing to offer.
    localparam logic [XLEN-1:0] PC_RESET_VEC = 32'h0000_3000;
    localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0000;

    // One buffered fetch: PC in the upper half, instruction word in the lower half.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifq_entry_t;

endpackage

// File: rtl/f_ifq_mem.sv
// Queue storage: one synchronous write port and one asynchronous read port.
// Contents are never reset; validity is tracked by the pointers in f_ifq.
module f_ifq_mem
    import f_ifq_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  ifq_entry_t    wdata,
    input  logic [AW-1:0] rd_addr,
    output ifq_entry_t    rdata
);

    ifq_entry_t mem [DEPTH];

    // Write the pushed entry into its slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wdata;
        end
    end

    // Head entry is visible in the same cycle it is addressed.
    assign rdata = mem[rd_addr];

endmodule

// File: rtl/f_ifq.sv
// Instruction fetch queue between F and D.
// Accepts {pc, instr} from fetch, backpressures fetch through f_we, and
// presents the oldest entry to decode. A flush discards everything buffered.
// Optional macro IFQ_BYPASS_EN: an entry arriving at an empty queue is
// forwarded to decode in the same cycle.
module f_ifq
    import f_ifq_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            f_valid,
    input  logic [XLEN-1:0] f_pc,
    input  logic [XLEN-1:0] f_instr,
    output logic            f_we,
    output logic            d_valid,
    output logic [XLEN-1:0] d_pc,
    output logic [XLEN-1:0] d_instr,
    input  logic            d_stall,
    input  logic            flush,
    output logic [AW:0]     count
);

    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;

    ifq_entry_t head;
    ifq_entry_t incoming;

    logic empty;
    logic full;
    logic byp;
    logic pop;
    logic deq;
    logic push;
    logic wr_en;

    assign incoming = '{pc: f_pc, instr: f_instr};
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;

`ifdef IFQ_BYPASS_EN
    // Forward a fresh entry straight to decode when nothing older is waiting.
    assign byp = empty & f_valid & ~flush;
`else
    assign byp = 1'b0;
`endif

    // Head presentation: stored entry, bypassed entry, or the nop pair.
    always_comb begin
        d_valid = ~empty | byp;
        d_pc    = PC_RESET_VEC;
        d_instr = NOP_INSTR;
        if (!empty) begin
            d_pc    = head.pc;
            d_instr = head.instr;
        end else if (byp) begin
            d_pc    = f_pc;
            d_instr = f_instr;
        end
    end

    // Handshake: a full queue still accepts when its head leaves this cycle.
    always_comb begin
        pop   = d_valid & ~d_stall;
        deq   = pop & ~empty;
        f_we  = flush | ~full | pop;
        push  = f_valid & f_we & ~flush;
        wr_en = push & ~(byp & pop);
    end

    // Pointer and occupancy update; reset beats flush beats push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, deq})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    f_ifq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we      (wr_en & ~reset & ~flush),
        .wr_addr (wr_ptr),
        .wdata   (incoming),
        .rd_addr (rd_ptr),
        .rdata   (head)
    );

endmodule

// File: tb/tb_f_ifq.sv
// Bench for f_ifq: directed vector table followed by randomized traffic
// checked against a queue-based reference model.
module tb_f_ifq;

`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int TB_DEPTH = 4;
    localparam logic [31:0] PCR = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        f_valid = 1'b0;
    logic [31:0] f_pc = '0;
    logic [31:0] f_instr = '0;
    logic        f_we;
    logic        d_valid;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_stall = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    logic [63:0] mq[$];

    typedef struct {
        logic        rst;
        logic        fv;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        st;
        logic        fl;
        logic        chk;
        logic        edv;
        logic [31:0] epc;
        logic [31:0] eins;
        logic        efwe;
        logic [2:0]  ecnt;
    } vec_t;

    vec_t vt[$];

    f_ifq dut (
        .clk     (clk),
        .reset   (reset),
        .f_valid (f_valid),
        .f_pc    (f_pc),
        .f_instr (f_instr),
        .f_we    (f_we),
        .d_valid (d_valid),
        .d_pc    (d_pc),
        .d_instr (d_instr),
        .d_stall (d_stall),
        .flush   (flush),
        .count   (count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic fv, input logic [31:0] pc,
                                input logic [31:0] ins, input logic st, input logic fl,
                                input logic chk, input logic edv, input logic [31:0] epc,
                                input logic [31:0] eins, input logic efwe, input logic [2:0] ecnt);
        vec_t v;
        v.rst = rst; v.fv = fv; v.pc = pc; v.ins = ins; v.st = st; v.fl = fl; v.chk = chk;
        v.edv = edv; v.epc = epc; v.eins = eins; v.efwe = efwe; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Reference: expected outputs from the current queue contents and inputs.
    task automatic model_eval(input vec_t v, output logic edv, output logic [31:0] epc,
                              output logic [31:0] eins, output logic efwe, output logic [2:0] ecnt,
                              output logic pop, output logic push, output logic byp);
        int n;
        n    = mq.size();
        byp  = BYP && (n == 0) && v.fv && !v.fl;
        edv  = (n != 0) || byp;
        epc  = PCR;
        eins = 32'h0;
        if (n != 0) begin
            epc  = mq[0][63:32];
            eins = mq[0][31:0];
        end else if (byp) begin
            epc  = v.pc;
            eins = v.ins;
        end
        pop  = edv && !v.st;
        efwe = v.fl || (n < TB_DEPTH) || pop;
        push = v.fv && efwe && !v.fl;
        ecnt = 3'(n);
    endtask

    // Reference: state change at the clock edge.
    task automatic model_commit(input vec_t v, input logic pop, input logic push, input logic byp);
        if (v.rst || v.fl) begin
            mq.delete();
        end else begin
            if (pop && mq.size() != 0) void'(mq.pop_front());
            if (push && !(byp && pop)) mq.push_back({v.pc, v.ins});
        end
    endtask

    task automatic step(input vec_t v, input bit use_tab, input int idx);
        logic        edv, efwe, pop, push, byp;
        logic [31:0] epc, eins;
        logic [2:0]  ecnt;
        @(negedge clk);
        reset   = v.rst;
        f_valid = v.fv;
        f_pc    = v.pc;
        f_instr = v.ins;
        d_stall = v.st;
        flush   = v.fl;
        #1;
        model_eval(v, edv, epc, eins, efwe, ecnt, pop, push, byp);
        if (use_tab) begin
            if (v.chk) begin
                chk("tab_d_valid", idx, 32'(d_valid), 32'(v.edv));
                chk("tab_d_pc",    idx, d_pc,         v.epc);
                chk("tab_d_instr", idx, d_instr,      v.eins);
                chk("tab_f_we",    idx, 32'(f_we),    32'(v.efwe));
                chk("tab_count",   idx, 32'(count),   32'(v.ecnt));
            end
        end else begin
            chk("rnd_d_valid", idx, 32'(d_valid), 32'(edv));
            chk("rnd_d_pc",    idx, d_pc,         epc);
            chk("rnd_d_instr", idx, d_instr,      eins);
            chk("rnd_f_we",    idx, 32'(f_we),    32'(efwe));
            chk("rnd_count",   idx, 32'(count),   32'(ecnt));
        end
        model_commit(v, pop, push, byp);
    endtask

    initial begin
        // Reset, then idle.
        vt.push_back(mk(1, 0, 32'h0, 32'h0, 0, 0, 0, 0, PCR, 32'h0, 1, 3'd0));
        vt.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 1, 0, PCR, 32'h0, 1, 3'd0));
        // Fill under stall; the fifth fetch is refused and re-presented.
        vt.push_back(mk(0, 1, 32'h3000, 32'h3401ffff, 1, 0, 1, BYP, PCR, BYP ? 32'h3401ffff : 32'h0, 1, 3'd0));
        vt.push_back(mk(0, 1, 32'h3004, 32'h3402ffff, 1, 0, 1, 1, 32'h3000, 32'h3401ffff, 1, 3'd1));
        vt.push_back(mk(0, 1, 32'h3008, 32'h3403ffff, 1, 0, 1, 1, 32'h3000, 32'h3401ffff, 1, 3'd2));
        vt.push_back(mk(0, 1, 32'h300C, 32'h3404ffff, 1, 0, 1, 1, 32'h3000, 32'h3401ffff, 1, 3'd3));
        vt.push_back(mk(0, 1, 32'h3010, 32'h3405ffff, 1, 0, 1, 1, 32'h3000, 32'h3401ffff, 0, 3'd4));
        vt.push_back(mk(0, 1, 32'h3010, 32'h3405ffff, 1, 0, 1, 1, 32'h3000, 32'h3401ffff, 0, 3'd4));
        // Release: pop and push together while full, then drain with wrap.
        vt.push_back(mk(0, 1, 32'h3010, 32'h3405ffff, 0, 0, 1, 1, 32'h3000, 32'h3401ffff, 1, 3'd4));
        vt.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 1, 1, 32'h3004, 32'h3402ffff, 1, 3'd4));
        vt.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 1, 1, 32'h3008, 32'h3403ffff, 1, 3'd3));
        vt.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 1, 1, 32'h300C, 32'h3404ffff, 1, 3'd2));
        vt.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 1, 1, 32'h3010, 32'h3405ffff, 1, 3'd1));
        vt.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 1, 0, PCR, 32'h0, 1, 3'd0));
        // Flush at count 3 with a same-cycle fetch.
        vt.push_back(mk(0, 1, 32'h3014, 32'h11111111, 1, 0, 1, BYP, BYP ? 32'h3014 : PCR, BYP ? 32'h11111111 : 32'h0, 1, 3'd0));
        vt.push_back(mk(0, 1, 32'h3018, 32'h22222222, 1, 0, 1, 1, 32'h3014, 32'h11111111, 1, 3'd1));
        vt.push_back(mk(0, 1, 32'h301C, 32'h33333333, 1, 0, 1, 1, 32'h3014, 32'h11111111, 1, 3'd2));
        vt.push_back(mk(0, 1, 32'h3020, 32'h44444444, 1, 1, 1, 1, 32'h3014, 32'h11111111, 1, 3'd3));
        vt.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 1, 0, PCR, 32'h0, 1, 3'd0));
        // Flush while full and stalled: f_we is forced high.
        vt.push_back(mk(0, 1, 32'h3040, 32'haaaa0001, 1, 0, 1, BYP, BYP ? 32'h3040 : PCR, BYP ? 32'haaaa0001 : 32'h0, 1, 3'd0));
        vt.push_back(mk(0, 1, 32'h3044, 32'haaaa0002, 1, 0, 1, 1, 32'h3040, 32'haaaa0001, 1, 3'd1));
        vt.push_back(mk(0, 1, 32'h3048, 32'haaaa0003, 1, 0, 1, 1, 32'h3040, 32'haaaa0001, 1, 3'd2));
        vt.push_back(mk(0, 1, 32'h304C, 32'haaaa0004, 1, 0, 1, 1, 32'h3040, 32'haaaa0001, 1, 3'd3));
        vt.push_back(mk(0, 1, 32'h3050, 32'haaaa0005, 1, 1, 1, 1, 32'h3040, 32'haaaa0001, 1, 3'd4));
        vt.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 1, 0, PCR, 32'h0, 1, 3'd0));
        // Reset mid-fill.
        vt.push_back(mk(0, 1, 32'h3060, 32'hbbbb0001, 1, 0, 1, BYP, BYP ? 32'h3060 : PCR, BYP ? 32'hbbbb0001 : 32'h0, 1, 3'd0));
        vt.push_back(mk(0, 1, 32'h3064, 32'hbbbb0002, 1, 0, 1, 1, 32'h3060, 32'hbbbb0001, 1, 3'd1));
        vt.push_back(mk(1, 0, 32'h0, 32'h0, 1, 0, 1, 1, 32'h3060, 32'hbbbb0001, 1, 3'd2));
        vt.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 1, 0, PCR, 32'h0, 1, 3'd0));
        // Empty-queue latency: same cycle with bypass, next cycle without.
        vt.push_back(mk(0, 1, 32'h3000, 32'h10210003, 0, 0, 1, BYP, PCR, BYP ? 32'h10210003 : 32'h0, 1, 3'd0));
        vt.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 1, !BYP, PCR, BYP ? 32'h0 : 32'h10210003, 1, BYP ? 3'd0 : 3'd1));
        vt.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 1, 0, PCR, 32'h0, 1, 3'd0));

        foreach (vt[i]) step(vt[i], 1'b1, i);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            vec_t v;
            v.rst  = ($urandom_range(0, 199) == 0);
            v.fv   = ($urandom_range(0, 9) < 7);
            v.pc   = $urandom;
            v.ins  = $urandom;
            v.st   = ($urandom_range(0, 9) < 4);
            v.fl   = ($urandom_range(0, 39) == 0);
            v.chk  = 1'b1;
            v.edv  = 1'b0;
            v.epc  = '0;
            v.eins = '0;
            v.efwe = 1'b0;
            v.ecnt = '0;
            step(v, 1'b0, i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
